// File: rtl/alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// alu_exec_ctrl
//   Four-state execution controller for a CR16-style ALU. It accepts one
//   instruction word, decodes the operands from a 16 x 16 register file,
//   presents them to an external combinational ALU, captures the ALU result
//   and flags, then writes back to the register file and/or the PSR.
//
// Ports
//   clk          sole clock, rising edge
//   reset        synchronous, active-high reset
//   instr_valid  instruction offered
//   instr        CR16 instruction word
//   instr_ready  controller can accept (IDLE and not in reset)
//   alu_a        ALU Rdest operand (registered)
//   alu_b        ALU Rsrc/Imm operand (registered)
//   alu_op       ALU opcode (registered)
//   alu_result   ALU result (combinational from the ALU)
//   alu_flags    ALU flags {L,C,F,Z,N}
//   psr          architectural flag register {L,C,F,Z,N}
//   done         one-cycle pulse when an instruction retires
//   illegal      one-cycle pulse with done for unsupported opcodes
//   dbg_addr     debug register-file read address
//   dbg_data     debug register-file read data (combinational)
// ----------------------------------------------------------------------------
module alu_exec_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic [7:0]  alu_op,
    input  logic [15:0] alu_result,
    input  logic [4:0]  alu_flags,
    output logic [4:0]  psr,
    output logic        done,
    output logic        illegal,
    input  logic [3:0]  dbg_addr,
    output logic [15:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle,
        StDecode,
        StExec,
        StWb
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [15:0] regs [16];
    logic [15:0] ir;
    logic [15:0] res;
    logic [4:0]  flg;

    logic        accept;
    logic [7:0]  dec_op;
    logic [15:0] dec_imm;
    logic [15:0] dec_a;
    logic [15:0] dec_b;
    logic        op_legal;
    logic        op_cmp;
    logic        op_wait;
    logic        wb_reg;
    logic        wb_psr;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        next_state = state;
        unique case (state)
            StIdle:   if (accept) next_state = StDecode;
            StDecode: next_state = StExec;
            StExec:   next_state = StWb;
            StWb:     next_state = StIdle;
            default:  next_state = StIdle;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / control logic
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready = (state == StIdle) && !reset;
        accept      = instr_valid && instr_ready;
        wb_reg      = (state == StWb) && op_legal && !op_cmp && !op_wait;
        wb_psr      = (state == StWb) && op_legal && !op_wait;
    end

    // ------------------------------------------------------------------
    // Decode of the latched instruction
    // ------------------------------------------------------------------
    always_comb begin
        if (ir[15:12] == 4'h0) begin
            dec_op = {4'h0, ir[7:4]};
        end else begin
            dec_op = {ir[15:12], 4'h0};
        end
        // MOVI takes an unsigned byte; every other immediate is signed.
        if (dec_op == 8'hD0) begin
            dec_imm = {8'h00, ir[7:0]};
        end else begin
            dec_imm = {{8{ir[7]}}, ir[7:0]};
        end
        dec_a = regs[ir[11:8]];
        dec_b = (ir[15:12] == 4'h0) ? regs[ir[3:0]] : dec_imm;
    end

    // Classification uses the registered opcode, which is stable in WB.
    // Immediate opcodes always have a zero low nibble by construction.
    always_comb begin
        if (alu_op[7:4] == 4'h0) begin
            op_legal = (alu_op[3:0] != 4'hA);
        end else begin
            op_legal = (alu_op[7:4] >= 4'h5) && (alu_op[7:4] != 4'hA);
        end
        op_cmp  = (alu_op == 8'h0B) || (alu_op == 8'hB0);
        op_wait = (alu_op == 8'h00);
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) begin
                regs[i] <= 16'h0000;
            end
            ir      <= 16'h0000;
            res     <= 16'h0000;
            flg     <= 5'b00000;
            psr     <= 5'b00000;
            alu_a   <= 16'h0000;
            alu_b   <= 16'h0000;
            alu_op  <= 8'h00;
            done    <= 1'b0;
            illegal <= 1'b0;
        end else begin
            // Retirement pulses land in the IDLE cycle that follows WB.
            done    <= (state == StWb);
            illegal <= (state == StWb) && !op_legal;

            if (accept) begin
                ir <= instr;
            end
            if (state == StDecode) begin
                alu_a  <= dec_a;
                alu_b  <= dec_b;
                alu_op <= dec_op;
            end
            if (state == StExec) begin
                res <= alu_result;
                flg <= alu_flags;
            end
            if (wb_reg) begin
                regs[ir[11:8]] <= res;
            end
            if (wb_psr) begin
                psr <= flg;
            end
        end
    end

    assign dbg_data = regs[dbg_addr];

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// ----------------------------------------------------------------------------
// tb_alu_exec_ctrl
//   Directed bench for alu_exec_ctrl with a small behavioural ALU stand-in.
//   Opcodes the stand-in does not model return a distinctive result/flags
//   pattern so that any unwanted writeback shows up in the register file.
// ----------------------------------------------------------------------------
module tb_alu_exec_ctrl;

    logic        clk;
    logic        reset;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [7:0]  alu_op;
    logic [15:0] alu_result;
    logic [4:0]  alu_flags;
    logic [4:0]  psr;
    logic        done;
    logic        illegal;
    logic [3:0]  dbg_addr;
    logic [15:0] dbg_data;

    int checks;
    int errors;

    alu_exec_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_flags   (alu_flags),
        .psr         (psr),
        .done        (done),
        .illegal     (illegal),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ALU stand-in, flags {L,C,F,Z,N}.
    logic [16:0] sum;
    logic [16:0] diff;
    always_comb begin
        sum        = {1'b0, alu_a} + {1'b0, alu_b};
        diff       = {1'b0, alu_a} - {1'b0, alu_b};
        alu_result = 16'h1234;
        alu_flags  = 5'b10101;
        case (alu_op)
            8'h05, 8'h50, 8'h06, 8'h60: begin
                alu_result = sum[15:0];
                alu_flags  = {1'b0, sum[16],
                              (alu_a[15] == alu_b[15]) && (sum[15] != alu_a[15]),
                              sum[15:0] == 16'h0000, sum[15]};
            end
            8'h09, 8'h90: begin
                alu_result = diff[15:0];
                alu_flags  = {alu_a < alu_b, diff[16],
                              (alu_a[15] != alu_b[15]) && (diff[15] != alu_a[15]),
                              diff[15:0] == 16'h0000, diff[15]};
            end
            8'h0B, 8'hB0: begin
                alu_result = diff[15:0];
                alu_flags  = {alu_a < alu_b, 1'b0, 1'b0, alu_a == alu_b,
                              $signed(alu_a) < $signed(alu_b)};
            end
            8'h0D, 8'hD0: begin
                alu_result = alu_b;
                alu_flags  = 5'b00000;
            end
            default: begin
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input logic [3:0] addr, input logic [15:0] exp, input string tag);
        dbg_addr = addr;
        #1;
        chk(tag, {16'h0, dbg_data}, {16'h0, exp});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one word, then check the retire latency and the illegal pulse.
    task automatic run(input logic [15:0] w, input logic exp_ill, input string tag);
        int k;
        k = 0;
        while (!instr_ready && k < 8) begin
            tick();
            k++;
        end
        chk({tag, "_ready"}, {31'h0, instr_ready}, 32'd1);
        instr_valid = 1'b1;
        instr       = w;
        tick();
        instr_valid = 1'b0;
        instr       = 16'h0000;
        k = 0;
        while (!done && k < 6) begin
            tick();
            k++;
        end
        chk({tag, "_latency"}, k, 32'd3);
        chk({tag, "_illegal"}, {31'h0, illegal}, {31'h0, exp_ill});
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int i = 0; i < cycles; i++) begin
            tick();
            if (done) n++;
        end
    endtask

    initial begin
        int n;
        checks      = 0;
        errors      = 0;
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        dbg_addr    = 4'h0;

        // Reset state
        tick();
        tick();
        chk("rst_ready", {31'h0, instr_ready}, 32'd0);
        chk("rst_done", {31'h0, done}, 32'd0);
        chk("rst_illegal", {31'h0, illegal}, 32'd0);
        chk("rst_psr", {27'h0, psr}, 32'd0);
        chk("rst_alu_a", {16'h0, alu_a}, 32'd0);
        chk("rst_alu_b", {16'h0, alu_b}, 32'd0);
        chk("rst_alu_op", {24'h0, alu_op}, 32'd0);
        rd(4'd5, 16'h0000, "rst_r5");
        reset = 1'b0;
        tick();
        chk("rst_release_ready", {31'h0, instr_ready}, 32'd1);

        // MOVI R1,0x7F
        run(16'hD17F, 1'b0, "movi");
        rd(4'd1, 16'h007F, "movi_r1");
        chk("movi_psr", {27'h0, psr}, 32'h00);
        tick();
        chk("done_one_cycle", {31'h0, done}, 32'd0);

        // SUBI R1,1 then ADDU R1,R1 from reset
        reset = 1'b1;
        tick();
        reset = 1'b0;
        run(16'h9101, 1'b0, "subi");
        rd(4'd1, 16'hFFFF, "subi_r1");
        chk("subi_psr", {27'h0, psr}, 32'h19);
        run(16'h0161, 1'b0, "addu");
        rd(4'd1, 16'hFFFE, "addu_r1");
        chk("addu_psr", {27'h0, psr}, 32'h09);

        // WAIT and an unsupported opcode leave all state alone
        run(16'h0000, 1'b0, "wait");
        chk("wait_psr", {27'h0, psr}, 32'h09);
        rd(4'd0, 16'h0000, "wait_r0");
        run(16'h02A3, 1'b1, "subc");
        chk("subc_psr", {27'h0, psr}, 32'h09);
        rd(4'd2, 16'h0000, "subc_r2");
        rd(4'd1, 16'hFFFE, "subc_r1");
        tick();
        chk("illegal_one_cycle", {31'h0, illegal}, 32'd0);

        // CMP updates flags only
        run(16'hD205, 1'b0, "movi_r2");
        run(16'hD305, 1'b0, "movi_r3");
        run(16'h02B3, 1'b0, "cmp");
        chk("cmp_psr", {27'h0, psr}, 32'h02);
        rd(4'd2, 16'h0005, "cmp_r2");

        // R0 is writable
        run(16'hD042, 1'b0, "movi_r0");
        rd(4'd0, 16'h0042, "r0_write");

        // Input changes while busy are ignored; signed immediate for ADDI
        instr_valid = 1'b1;
        instr       = 16'h5180;
        tick();
        chk("busy_ready_dec", {31'h0, instr_ready}, 32'd0);
        instr = 16'hD1FF;
        tick();
        chk("busy_ready_exec", {31'h0, instr_ready}, 32'd0);
        chk("addi_op", {24'h0, alu_op}, 32'h50);
        chk("addi_b_sext", {16'h0, alu_b}, 32'hFF80);
        chk("addi_a", {16'h0, alu_a}, 32'hFFFE);
        instr = 16'h0161;
        tick();
        chk("busy_ready_wb", {31'h0, instr_ready}, 32'd0);
        chk("busy_done_wb", {31'h0, done}, 32'd0);
        instr = 16'hD1AA;
        tick();
        chk("busy_done", {31'h0, done}, 32'd1);
        instr_valid = 1'b0;
        rd(4'd1, 16'hFF7E, "addi_r1");
        chk("addi_psr", {27'h0, psr}, 32'h09);
        count_done(5, n);
        chk("busy_extra_done", n, 32'd0);
        rd(4'd1, 16'hFF7E, "busy_r1_hold");

        // Reset during EXEC aborts the instruction
        instr_valid = 1'b1;
        instr       = 16'hD1AA;
        tick();
        instr_valid = 1'b0;
        tick();
        chk("abort_op", {24'h0, alu_op}, 32'hD0);
        chk("abort_b_zext", {16'h0, alu_b}, 32'h00AA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("abort_ready", {31'h0, instr_ready}, 32'd1);
        count_done(5, n);
        chk("abort_no_done", n, 32'd0);
        rd(4'd1, 16'h0000, "abort_r1");
        rd(4'd2, 16'h0000, "abort_r2");
        chk("abort_psr", {27'h0, psr}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so the bench always ends.
    initial begin
        #100000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_exec_ctrl.md
ALU_EXEC_CTRL -- requirements
Module: alu_exec_ctrl

Interface
REQ-001 SHALL have parameters: none; the register file is fixed at 16 x 16 bits and the PSR at 5 bits.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 instr_valid  in  1  instruction offered.
REQ-005 instr  in  16  CR16 instruction word.
REQ-006 instr_ready  out  1  controller can accept.
REQ-007 alu_a  out  16  drives ALU Rdest.
REQ-008 alu_b  out  16  drives ALU Rsrc_Imm.
REQ-009 alu_op  out  8  drives ALU Opcode.
REQ-010 alu_result  in  16  ALU Result (combinational).
REQ-011 alu_flags  in  5  ALU Flags, {L,C,F,Z,N} as bits [4:0].
REQ-012 psr  out  5  architectural flag register, same bit map.
REQ-013 done  out  1  one-cycle pulse when an instruction retires.
REQ-014 illegal  out  1  one-cycle pulse, coincident with done, for unsupported opcodes.
REQ-015 dbg_addr  in  4 / dbg_data  out  16  combinational register-file read port.

Function
REQ-016 SHALL implement FSM IDLE -> DECODE -> EXEC -> WB -> IDLE, one state per cycle.
REQ-017 instr_ready SHALL equal (state==IDLE) and not reset; transfer occurs on a clk edge with instr_valid & instr_ready, latching instr and entering DECODE.
REQ-018 Outside IDLE, instr and instr_valid SHALL be ignored; latched instruction is immune to input changes.
REQ-019 Decode: instr[15:12]==0 -> alu_op={4'h0,instr[7:4]}, alu_b=R[instr[3:0]]; otherwise alu_op={instr[15:12],4'h0}, alu_b=immediate instr[7:0].
REQ-020 Immediate SHALL be zero-extended for MOVI (0xD0), sign-extended for all other immediate opcodes.
REQ-021 alu_a SHALL be R[instr[11:8]]; operands and alu_op SHALL be registered at end of DECODE and held stable through EXEC and WB.
REQ-022 At end of EXEC, alu_result and alu_flags SHALL be captured into internal result/flag registers.
REQ-023 In WB: supported non-compare ops write result to R[instr[11:8]] and flags to psr; CMP/CMPI (0x0B/0xB0) update psr only; WAIT (0x00) writes neither.
REQ-024 Supported set: 0x01-0x09,0x0B-0x0F, 0x50,0x60,0x70,0x80,0x90,0xB0,0xC0,0xD0,0xE0,0xF0, 0x00; all others (e.g. 0x0A, 0xA0, 0x10-0x40) SHALL write nothing, hold psr, and pulse illegal.
REQ-025 done SHALL assert during the cycle after WB (i.e. in IDLE) for exactly one cycle; accept at edge N -> done high in cycle N+3, writeback visible on dbg_data from that cycle.
REQ-026 Maximum throughput SHALL be one instruction per 4 cycles; a new transfer may occur on the same edge done is high.
REQ-027 Source and destination may be the same register; operands SHALL be the pre-instruction values.
REQ-028 R0 SHALL be an ordinary writable register.

Reset
REQ-029 While reset is high at a clk edge: state=IDLE, all 16 registers=0, psr=0, alu_a=alu_b=0, alu_op=0x00, done=illegal=0.
REQ-030 Reset in any state SHALL abort the instruction with no register or psr write; instr_ready SHALL rise the cycle after reset deasserts.

Verification
REQ-031 Reset, then 0xD17F -> done at N+3, R1=0x007F, psr=5'b00000.
REQ-032 From reset, 0x9101 (SUBI R1,1) -> R1=0xFFFF, psr=5'b11001; then 0x0161 (ADDU R1,R1) -> R1=0xFFFE, psr=5'b01001.
REQ-033 0xD205, 0xD305, then 0x02B3 (CMP R2,R3) -> psr=5'b00010, R2 stays 0x0005.
REQ-034 psr=5'b01001, issue 0x0000 (WAIT) then 0x02A3 (SUBC) -> both pulse done, second pulses illegal, psr and all registers unchanged.
REQ-035 Hold instr_valid high with changing instr during DECODE/EXEC/WB -> instr_ready=0, only the first word executes, exactly one done.
REQ-036 Assert reset for one cycle while in EXEC of 0xD1AA -> R1=0x0000, no done, instr_ready=1 the cycle after reset drops.
